multichannel_cascade_ema_filter: RTL and testbench

- Parametrised successor to the single-channel cascade low-pass filter.
- Filters NUM_CH signed channels in parallel, each through STAGES first-order EMA (2^-k) sections.
- Shift k is runtime-configurable per channel; a stage-enable mask applies to all channels.
- Stages are processed serially on one shared subtract/shift/add datapath per channel. Adds first-sample priming, synchronous clear, a ready/valid handshake and overrun detection. Sits between ADC/demodulator outputs and the lock servo.

---
 rtl/multichannel_cascade_ema_filter_pkg.sv | 13 +
 rtl/multichannel_cascade_ema_filter_alu.sv | 29 ++
 rtl/multichannel_cascade_ema_filter.sv | 133 +++++++++++++
 tb/tb_multichannel_cascade_ema_filter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/multichannel_cascade_ema_filter_pkg.sv
// Shared types and constants for the multichannel cascade EMA filter.
// Holds the FSM encoding and the default shift-field width.
package multichannel_cascade_ema_filter_pkg;

  localparam int EMA_SHIFT_W = 4;

  typedef enum logic [1:0] {
    EMA_IDLE = 2'd0,
    EMA_RUN  = 2'd1,
    EMA_DONE = 2'd2
  } ema_state_t;

endpackage

// File: rtl/multichannel_cascade_ema_filter_alu.sv
// One EMA section update for a single channel: y_next = y + ((u - y) >>> k), or u when bypassed.
// Purely combinational; the extra difference bit keeps u - y exact across the full state range.
module ema_stage_alu
  import multichannel_cascade_ema_filter_pkg::*;
#(
  parameter int SW      = 31,
  parameter int SHIFT_W = EMA_SHIFT_W
) (
  input  logic signed [SW-1:0]      y,
  input  logic signed [SW-1:0]      u,
  input  logic        [SHIFT_W-1:0] k,
  input  logic                      bypass,
  output logic signed [SW-1:0]      y_next
);

  logic signed [SW:0]   diff;
  logic signed [SW:0]   step;
  logic signed [SW-1:0] sum;
  logic                 unused_step_msb;

  assign diff = $signed({u[SW-1], u}) - $signed({y[SW-1], y});
  assign step = diff >>> k;
  // The scaled step of a bounded EMA always fits the state width.
  assign sum  = y + $signed(step[SW-1:0]);
  assign unused_step_msb = step[SW];

  assign y_next = bypass ? u : sum;

endmodule

// File: rtl/multichannel_cascade_ema_filter.sv
// NUM_CH parallel channels, each through STAGES EMA sections run serially on one shared ALU.
// Sample accepted in IDLE, one stage per RUN cycle, out_valid in DONE; in_valid during RUN is dropped and flagged.
module multichannel_cascade_ema_filter
  import multichannel_cascade_ema_filter_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int STAGES  = 4,
  parameter int DATA_W  = 16,
  parameter int SHIFT_W = EMA_SHIFT_W,
  parameter int FRAC_W  = (1 << SHIFT_W) - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic [NUM_CH*SHIFT_W-1:0]  cfg_shift,
  input  logic [STAGES-1:0]          cfg_stage_en,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [NUM_CH*DATA_W-1:0]   out_data,
  output logic                       out_valid,
  output logic                       overrun
);

  localparam int SW     = DATA_W + FRAC_W;
  localparam int SIDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [SIDX_W-1:0] S_LAST = SIDX_W'(STAGES - 1);

  ema_state_t state_q, state_d;

  logic [SIDX_W-1:0]         s_q;
  logic [SIDX_W-1:0]         s_prev;
  logic                      primed;
  logic [NUM_CH*DATA_W-1:0]  x_lat;
  logic [NUM_CH*SHIFT_W-1:0] k_lat;
  logic [STAGES-1:0]         en_lat;
  logic                      bypass;

  logic signed [SW-1:0] y_q    [NUM_CH][STAGES];
  logic signed [SW-1:0] y_next [NUM_CH];

  assign in_ready  = (state_q == EMA_IDLE);
  assign out_valid = (state_q == EMA_DONE) && !clr && !rst;
  assign s_prev    = s_q - SIDX_W'(1);
  assign bypass    = !primed || !en_lat[s_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMA_IDLE: if (in_valid) state_d = EMA_RUN;
      EMA_RUN:  if (s_q == S_LAST) state_d = EMA_DONE;
      EMA_DONE: state_d = EMA_IDLE;
      default:  state_d = EMA_IDLE;
    endcase
    if (clr) state_d = EMA_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMA_IDLE;
    else     state_q <= state_d;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic signed [SW-1:0] x_al;
    logic signed [SW-1:0] u;
    logic signed [SW-1:0] y_cur;

    assign x_al  = {x_lat[c*DATA_W +: DATA_W], {FRAC_W{1'b0}}};
    // Stage s>0 consumes stage s-1 as already updated for this sample.
    assign u     = (s_q == '0) ? x_al : y_q[c][s_prev];
    assign y_cur = y_q[c][s_q];

    ema_stage_alu #(
      .SW      (SW),
      .SHIFT_W (SHIFT_W)
    ) u_alu (
      .y      (y_cur),
      .u      (u),
      .k      (k_lat[c*SHIFT_W +: SHIFT_W]),
      .bypass (bypass),
      .y_next (y_next[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q      <= '0;
      primed   <= 1'b0;
      x_lat    <= '0;
      k_lat    <= '0;
      en_lat   <= '0;
      out_data <= '0;
      for (int c = 0; c < NUM_CH; c++)
        for (int s = 0; s < STAGES; s++)
          y_q[c][s] <= '0;
    end else if (clr) begin
      primed <= 1'b0;
      for (int c = 0; c < NUM_CH; c++)
        for (int s = 0; s < STAGES; s++)
          y_q[c][s] <= '0;
    end else begin
      case (state_q)
        EMA_IDLE: begin
          if (in_valid) begin
            x_lat  <= in_data;
            k_lat  <= cfg_shift;
            en_lat <= cfg_stage_en;
            s_q    <= '0;
          end
        end
        EMA_RUN: begin
          for (int c = 0; c < NUM_CH; c++)
            y_q[c][s_q] <= y_next[c];
          if (s_q == S_LAST) begin
            // Capture the final stage directly so out_data is ready in DONE.
            for (int c = 0; c < NUM_CH; c++)
              out_data[c*DATA_W +: DATA_W] <= y_next[c][FRAC_W +: DATA_W];
          end else begin
            s_q <= s_q + SIDX_W'(1);
          end
        end
        EMA_DONE: primed <= 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                  overrun <= 1'b0;
    else if (!clr && in_valid && !in_ready)   overrun <= 1'b1;
  end

endmodule

// File: tb/tb_multichannel_cascade_ema_filter.sv
// Directed bench: two channels, two stages, 16-bit samples, hand-computed expectations.
module tb_multichannel_cascade_ema_filter;

  localparam int NUM_CH = 2;
  localparam int STAGES = 2;
  localparam int DATA_W = 16;
  localparam int SHIFT_W = 4;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      clr = 1'b0;
  logic [NUM_CH*SHIFT_W-1:0] cfg_shift = '0;
  logic [STAGES-1:0]         cfg_stage_en = '0;
  logic [NUM_CH*DATA_W-1:0]  in_data = '0;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic [NUM_CH*DATA_W-1:0]  out_data;
  logic                      out_valid;
  logic                      overrun;

  int checks = 0;
  int passes = 0;

  multichannel_cascade_ema_filter #(
    .NUM_CH(NUM_CH), .STAGES(STAGES), .DATA_W(DATA_W), .SHIFT_W(SHIFT_W)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .cfg_shift(cfg_shift),
    .cfg_stage_en(cfg_stage_en), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .overrun(overrun)
  );

  always #2 clk = ~clk;

  typedef struct {
    bit clr_first;
    int d0, d1, k0, k1, en;
    int e0, e1;
  } vec_t;

  vec_t vt[16];
  int   nv;

  function automatic int ch(input int c);
    logic signed [DATA_W-1:0] v;
    v = out_data[c*DATA_W +: DATA_W];
    return int'(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int d0, input int d1, input int k0, input int k1, input int en);
    in_data      = {16'(d1), 16'(d0)};
    cfg_shift    = {4'(k1), 4'(k0)};
    cfg_stage_en = 2'(en);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Accepts one sample, then waits (bounded) for the strobe; lat counts cycles from acceptance.
  task automatic send(input int d0, input int d1, input int k0, input int k1, input int en,
                      output int o0, output int o1, output int lat);
    set_in(d0, d1, k0, k1, en);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    o0 = ch(0);
    o1 = ch(1);
    tick();
  endtask

  function automatic vec_t mk(input bit c, input int d0, input int d1, input int k0,
                              input int k1, input int en, input int e0, input int e1);
    vec_t v;
    v.clr_first = c; v.d0 = d0; v.d1 = d1; v.k0 = k0; v.k1 = k1; v.en = en;
    v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  initial begin
    int o0, o1, lat, strobes;

    nv = 0;
    // Step response: ch0 k=1 single stage, ch1 k=0.
    vt[nv++] = mk(1, 0,    0,    1, 0, 1, 0,   0);
    vt[nv++] = mk(0, 1000, 1000, 1, 0, 1, 500, 1000);
    vt[nv++] = mk(0, 1000, 1000, 1, 0, 1, 750, 1000);
    vt[nv++] = mk(0, 1000, 1000, 1, 0, 1, 875, 1000);
    vt[nv++] = mk(0, 1000, 1000, 1, 0, 1, 937, 1000);
    // Cascade of two k=1 stages.
    vt[nv++] = mk(1, 0,    0,     1, 0, 3, 0,   0);
    vt[nv++] = mk(0, 1000, -1000, 1, 0, 3, 250, -1000);
    vt[nv++] = mk(0, 1000, -1000, 1, 0, 3, 500, -1000);
    // Negative inputs: floor behaviour of the arithmetic shift.
    vt[nv++] = mk(1, 0,     0,      2, 15, 1, 0,    0);
    vt[nv++] = mk(0, -1000, -32768, 2, 15, 1, -250, -1);
    vt[nv++] = mk(0, -1000, -32768, 2, 15, 1, -438, -2);
    vt[nv++] = mk(0, -1000, -32768, 2, 15, 1, -579, -3);
    // Full-scale swing with k=15 must not wrap.
    vt[nv++] = mk(1, -32768, 32767,  15, 15, 3, -32768, 32767);
    vt[nv++] = mk(0, 32767,  -32768, 15, 15, 3, -32768, 32766);

    // Reset state.
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_overrun", int'(overrun), 0);

    // First sample after reset primes every stage exactly.
    send(1234, -500, 1, 1, 3, o0, o1, lat);
    chk("prime_lat", lat, 3);
    chk("prime_ch0", o0, 1234);
    chk("prime_ch1", o1, -500);
    repeat (3) tick();
    chk("hold_ch0", ch(0), 1234);
    chk("hold_valid", int'(out_valid), 0);

    for (int i = 0; i < nv; i++) begin
      if (vt[i].clr_first) do_clr();
      send(vt[i].d0, vt[i].d1, vt[i].k0, vt[i].k1, vt[i].en, o0, o1, lat);
      chk($sformatf("vec%0d_lat", i), lat, 3);
      chk($sformatf("vec%0d_ch0", i), o0, vt[i].e0);
      chk($sformatf("vec%0d_ch1", i), o1, vt[i].e1);
    end
    chk("no_overrun_yet", int'(overrun), 0);

    // Overrun: second strobe during RUN is dropped, its config change ignored.
    do_clr();
    send(0, 0, 1, 0, 1, o0, o1, lat);
    set_in(1000, 1000, 1, 0, 1);
    in_valid = 1'b1;
    tick();
    set_in(5000, 9999, 0, 0, 1);
    tick();
    in_valid = 1'b0;
    strobes = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) begin
        strobes++;
        o0 = ch(0);
        o1 = ch(1);
      end
      tick();
    end
    chk("ovr_strobes", strobes, 1);
    chk("ovr_ch0", o0, 500);
    chk("ovr_ch1", o1, 1000);
    chk("ovr_flag", int'(overrun), 1);
    send(1000, 1000, 1, 0, 1, o0, o1, lat);
    chk("ovr_sticky", int'(overrun), 1);
    chk("ovr_next_ch0", o0, 750);

    // clr during the last RUN stage aborts the sample.
    set_in(3000, 3000, 1, 1, 3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_in_ready", int'(in_ready), 1);
    strobes = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) strobes++;
      tick();
    end
    chk("clr_no_strobe", strobes, 0);
    chk("clr_keep_data", ch(0), 750);
    chk("clr_keep_ovr", int'(overrun), 1);
    send(777, -777, 1, 1, 3, o0, o1, lat);
    chk("reprime_lat", lat, 3);
    chk("reprime_ch0", o0, 777);
    chk("reprime_ch1", o1, -777);

    // rst beats clr.
    rst = 1'b1;
    clr = 1'b1;
    tick();
    rst = 1'b0;
    clr = 1'b0;
    chk("rstclr_data", int'(out_data), 0);
    chk("rstclr_ovr", int'(overrun), 0);
    chk("rstclr_valid", int'(out_valid), 0);
    chk("rstclr_ready", int'(in_ready), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
